sram_bus_arbiter: RTL

- Two-requester arbiter and access sequencer for the shared data-memory bus that drives the data-memory address decoder (address, read, write inputs).
- Requester 0 is the UART receive path writing captured bytes to SRAM; requester 1 is the filter/display path reading and writing SRAM.
- Grants by round-robin and sequences each access as setup, strobe and acknowledge phases, so the decoder sees stable address/strobe timing and CE/OE/WE never glitch between requesters.

---
 rtl/sram_bus_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Round-robin arbiter and access sequencer for the shared data-memory bus.
//   Requester 0 is the UART receive path; requester 1 is the filter/display path.
//   Each access runs IDLE -> SETUP (1) -> STROBE (WAIT) -> DONE (1) -> IDLE.
//   Every output is registered, so the decoder never sees a combinational
//   glitch on address or strobes when ownership changes.
//
// Ports
//   clk, nRESET            clock, synchronous active-low reset
//   reqN/weN/addrN/wdataN  requester N access (held until ackN)
//   ackN                   one-cycle completion pulse to requester N
//   rdata                  read data, valid with ack, held until next read
//   gnt                    one-hot owner, 00 when idle
//   mem_addr/mem_read/mem_write/mem_wdata/mem_rdata  decoder / SRAM side
//   busy                   high whenever the sequencer is not in IDLE
module sram_bus_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  generate
    if (WAIT < 1 || WAIT > 15) begin : g_bad_wait
      $error("sram_bus_arbiter: WAIT must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;       // 0 = requester 0, 1 = requester 1
  logic          last_owner_q, last_owner_d;
  logic          we_lat_q, we_lat_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_lat_d     = we_lat_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Contention goes to whoever was not served last.
          owner_d     = (req0 && req1) ? ~last_owner_q : req1;
          we_lat_d    = owner_d ? we1    : we0;
          mem_addr_d  = owner_d ? addr1  : addr0;
          mem_wdata_d = owner_d ? wdata1 : wdata0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_INIT;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          if (!we_lat_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    busy_d      = (state_d != IDLE);
    gnt_d       = busy_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    mem_write_d = (state_d == STROBE) &&  we_lat_d;
    mem_read_d  = (state_d == STROBE) && !we_lat_d;
    ack0_d      = (state_d == DONE) && !owner_d;
    ack1_d      = (state_d == DONE) &&  owner_d;
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_lat_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      gnt_q        <= 2'b00;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_lat_q     <= we_lat_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      gnt_q        <= gnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign gnt       = gnt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
